// File: rtl/dbi_req_arbiter_pkg.sv
// Shared types and defaults for the DBI requester arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dbi_arb_pkg;

  // Width of grant_id / last_grant; covers up to 8 requesters.
  localparam int GRANT_W = 3;

  localparam int          TIMEOUT_DEFAULT  = 200;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;

  // One-hot FSM encoding.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_WAIT = 3'b010,
    ST_GAP  = 3'b100
  } state_e;

endpackage

// File: rtl/dbi_req_arbiter_if.sv
// Requester bundle plus DBI bus seen by the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requests are held until the matching ack/err pulse.
interface dbi_req_arbiter_if
  import dbi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic                   dbi_ready;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*4-1:0]   req_wr;
  logic [NUM_REQ*32-1:0]  req_addr;
  logic [NUM_REQ*32-1:0]  req_din;
  logic [NUM_REQ-1:0]     req_cs2_exp;
  logic [NUM_REQ-1:0]     req_ack;
  logic [NUM_REQ-1:0]     req_err;
  logic [31:0]            req_dout;
  logic                   dbi_cs;
  logic                   dbi_cs2_exp;
  logic [3:0]             dbi_wr;
  logic [31:0]            dbi_addr;
  logic [31:0]            dbi_din;
  logic                   dbi_ack;
  logic [31:0]            dbi_dout;
  logic                   busy;
  logic [GRANT_W-1:0]     grant_id;

  // The arbiter owns the DBI bus and the response pulses.
  modport master (
    input  dbi_ready, req_valid, req_wr, req_addr, req_din, req_cs2_exp,
    input  dbi_ack, dbi_dout,
    output req_ack, req_err, req_dout,
    output dbi_cs, dbi_cs2_exp, dbi_wr, dbi_addr, dbi_din,
    output busy, grant_id
  );

  // Requesters and the DBI target on the other side.
  modport slave (
    output dbi_ready, req_valid, req_wr, req_addr, req_din, req_cs2_exp,
    output dbi_ack, dbi_dout,
    input  req_ack, req_err, req_dout,
    input  dbi_cs, dbi_cs2_exp, dbi_wr, dbi_addr, dbi_din,
    input  busy, grant_id
  );

endinterface

// File: rtl/dbi_req_arbiter_rr_pick.sv
// Round-robin selector: first valid requester scanning up from last_grant+1.
// Latency: combinational.
// Backpressure: none; pick_valid is low when no requester is valid.
module rr_pick
  import dbi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [GRANT_W-1:0] last_grant,
  output logic               pick_valid,
  output logic [GRANT_W-1:0] pick_id
);

  localparam int IDX_W = GRANT_W + 1;

  logic [IDX_W-1:0] idx;

  // Walk the NUM_REQ positions after last_grant with wrap; earliest valid one wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = {1'b0, last_grant} + IDX_W'(i);
      if (idx >= IDX_W'(NUM_REQ)) begin
        idx = idx - IDX_W'(NUM_REQ);
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!pick_valid && req_valid[j] && (idx == IDX_W'(j))) begin
          pick_valid = 1'b1;
          pick_id    = GRANT_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/dbi_req_arbiter.sv
// Round-robin arbiter sharing the PCIe DBI register bus among NUM_REQ requesters.
// Latency: dbi_cs one cycle after request; ack/err pulse one cycle after dbi_ack or timeout.
// Backpressure: requests wait in IDLE while dbi_ready is low or another transaction is in flight.
module dbi_req_arbiter
  import dbi_arb_pkg::*;
#(
  parameter int          NUM_REQ  = 2,
  parameter int          TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input logic               core_clk,
  input logic               core_rst,
  dbi_req_arbiter_if.master bus
);

  // Counter value on the last cycle dbi_cs may stay high without an ack.
  localparam logic [7:0]         CNT_LAST = 8'(TIMEOUT - 1);
  // Pointing last_grant at the top requester makes requester 0 win first.
  localparam logic [GRANT_W-1:0] LAST_RST = GRANT_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [GRANT_W-1:0]   grant_q, grant_d;
  logic [GRANT_W-1:0]   last_q, last_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 cs_q, cs_d;
  logic                 cs2_q, cs2_d;
  logic [3:0]           wr_q, wr_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          din_q, din_d;
  logic [31:0]          dout_q, dout_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   err_q, err_d;

  logic                 pick_vld;
  logic [GRANT_W-1:0]   pick_id;
  logic                 sel_cs2;
  logic [3:0]           sel_wr;
  logic [31:0]          sel_addr;
  logic [31:0]          sel_din;
  logic [NUM_REQ-1:0]   gnt_oh;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_valid  (bus.req_valid),
    .last_grant (last_q),
    .pick_valid (pick_vld),
    .pick_id    (pick_id)
  );

  // Steer the winning requester's slice onto one set of candidate bus fields.
  always_comb begin
    sel_cs2  = 1'b0;
    sel_wr   = '0;
    sel_addr = '0;
    sel_din  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_id == GRANT_W'(i)) begin
        sel_cs2  = bus.req_cs2_exp[i];
        sel_wr   = bus.req_wr[i*4 +: 4];
        sel_addr = bus.req_addr[i*32 +: 32];
        sel_din  = bus.req_din[i*32 +: 32];
      end
    end
  end

  // One-hot form of the granted index, used to steer the completion pulse.
  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_oh[i] = (grant_q == GRANT_W'(i));
    end
  end

  // FSM next state, field latching, timeout counting and response generation.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    cs2_d   = cs2_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    ack_d   = '0;
    err_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.dbi_ready && pick_vld) begin
          grant_d = pick_id;
          last_d  = pick_id;
          cnt_d   = '0;
          cs_d    = 1'b1;
          cs2_d   = sel_cs2;
          wr_d    = sel_wr;
          addr_d  = sel_addr;
          din_d   = sel_din;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // An ack on the final timeout cycle still counts as a good completion.
        if (bus.dbi_ack) begin
          cs_d    = 1'b0;
          dout_d  = bus.dbi_dout;
          ack_d   = gnt_oh;
          state_d = ST_GAP;
        end else if (cnt_q == CNT_LAST) begin
          cs_d    = 1'b0;
          dout_d  = ERR_DATA;
          err_d   = gnt_oh;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops dbi_cs at once and suppresses any pulse.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      cs_q    <= 1'b0;
      cs2_q   <= 1'b0;
      wr_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      ack_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      cs2_q   <= cs2_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign bus.dbi_cs      = cs_q;
  assign bus.dbi_cs2_exp = cs2_q;
  assign bus.dbi_wr      = wr_q;
  assign bus.dbi_addr    = addr_q;
  assign bus.dbi_din     = din_q;
  assign bus.req_ack     = ack_q;
  assign bus.req_err     = err_q;
  assign bus.req_dout    = dout_q;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dbi_req_arbiter.sv
// Directed bench for dbi_req_arbiter with grant/response scoreboards.
// Latency: n/a.
// Backpressure: requesters hold valid until their ack/err pulse.
module tb_dbi_req_arbiter;
  import dbi_arb_pkg::*;

  localparam int NR = 2;
  localparam int TO = 200;

  typedef struct packed {
    logic [2:0]  id;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  wr;
    logic        cs2;
  } gnt_t;

  typedef struct packed {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] dout;
  } rsp_t;

  logic core_clk = 1'b0;
  logic core_rst = 1'b1;

  dbi_req_arbiter_if #(.NUM_REQ(NR)) bus ();

  dbi_req_arbiter #(
    .NUM_REQ  (NR),
    .TIMEOUT  (TO),
    .ERR_DATA (32'hFFFF_FFFF)
  ) dut (
    .core_clk (core_clk),
    .core_rst (core_rst),
    .bus      (bus.master)
  );

  always #5 core_clk = ~core_clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  gnt_t        exp_gnt[$];
  rsp_t        exp_rsp[$];
  int          rise_cyc[$];
  int          ack_dly = 1;
  logic [31:0] resp_data = 32'h0;
  int          cs_cnt = 0;
  int          last_cs_len = 0;
  int          pend[NR] = '{0, 0};
  int          cyc = 0;

  always @(posedge core_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic gnt_t mk_gnt(input logic [2:0] id, input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] w, input logic c2);
    gnt_t g;
    g.id = id; g.addr = a; g.din = d; g.wr = w; g.cs2 = c2;
    return g;
  endfunction

  function automatic rsp_t mk_rsp(input logic [1:0] a, input logic [1:0] e, input logic [31:0] d);
    rsp_t r;
    r.ack = a; r.err = e; r.dout = d;
    return r;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] w, input logic c2);
    bus.req_addr[i*32 +: 32] = a;
    bus.req_din[i*32 +: 32]  = d;
    bus.req_wr[i*4 +: 4]     = w;
    bus.req_cs2_exp[i]       = c2;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge core_clk);
      if (exp_gnt.size() == 0 && exp_rsp.size() == 0 && bus.busy === 1'b0) done = 1'b1;
    end
    chk(tag, done, 1'b1);
  endtask

  task automatic wait_cs(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge core_clk);
      if (bus.dbi_cs === 1'b1) seen = 1'b1;
    end
    chk(tag, seen, 1'b1);
  endtask

  // DBI target: acks when dbi_cs has been visible for ack_dly cycles (0 = never).
  initial begin
    bus.dbi_ack  = 1'b0;
    bus.dbi_dout = 32'h0;
    forever begin
      @(posedge core_clk);
      #1;
      if (bus.dbi_cs === 1'b1) begin
        cs_cnt++;
      end else begin
        if (cs_cnt != 0) last_cs_len = cs_cnt;
        cs_cnt = 0;
      end
      bus.dbi_ack  = (bus.dbi_cs === 1'b1) && (cs_cnt == ack_dly);
      bus.dbi_dout = bus.dbi_ack ? resp_data : 32'hDEAD_BEEF;
    end
  end

  // Requesters: drop valid in the pulse cycle, raise a pending request one cycle later.
  initial begin
    bus.req_valid = '0;
    forever begin
      @(posedge core_clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (bus.req_ack[i] === 1'b1 || bus.req_err[i] === 1'b1) begin
          bus.req_valid[i] = 1'b0;
        end else if (!bus.req_valid[i] && pend[i] > 0) begin
          bus.req_valid[i] = 1'b1;
          pend[i]--;
        end
      end
    end
  end

  // Monitor: compare bus fields on each dbi_cs rise and each ack/err pulse against the queues.
  initial begin
    logic cs_prev;
    logic pulse;
    logic pulse_prev;
    gnt_t g;
    rsp_t r;
    cs_prev    = 1'b0;
    pulse_prev = 1'b0;
    forever begin
      @(negedge core_clk);
      if (bus.dbi_cs === 1'b1 && !cs_prev) begin
        rise_cyc.push_back(cyc);
        if (exp_gnt.size() == 0) begin
          chk("gnt_unexpected", exp_gnt.size(), 1);
        end else begin
          g = exp_gnt.pop_front();
          chk("gnt_id",   bus.grant_id,    g.id);
          chk("gnt_addr", bus.dbi_addr,    g.addr);
          chk("gnt_din",  bus.dbi_din,     g.din);
          chk("gnt_wr",   bus.dbi_wr,      g.wr);
          chk("gnt_cs2",  bus.dbi_cs2_exp, g.cs2);
          chk("gnt_busy", bus.busy,        1'b1);
        end
      end
      cs_prev = (bus.dbi_cs === 1'b1);
      pulse   = (|bus.req_ack) || (|bus.req_err);
      if (pulse) begin
        chk("pulse_single", pulse_prev, 1'b0);
        chk("pulse_cs_low", bus.dbi_cs, 1'b0);
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", exp_rsp.size(), 1);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_ack",  bus.req_ack,  r.ack);
          chk("rsp_err",  bus.req_err,  r.err);
          chk("rsp_dout", bus.req_dout, r.dout);
        end
      end
      pulse_prev = pulse;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_hi;
    bus.dbi_ready   = 1'b1;
    bus.req_wr      = '0;
    bus.req_addr    = '0;
    bus.req_din     = '0;
    bus.req_cs2_exp = '0;

    // Reset state
    repeat (3) @(posedge core_clk);
    #1;
    chk("rst_cs",    bus.dbi_cs,   1'b0);
    chk("rst_busy",  bus.busy,     1'b0);
    chk("rst_ack",   bus.req_ack,  2'b00);
    chk("rst_err",   bus.req_err,  2'b00);
    chk("rst_dout",  bus.req_dout, 32'h0);
    chk("rst_grant", bus.grant_id, 3'd0);
    core_rst = 1'b0;

    // Single write from requester 0, acked on the third cs cycle
    set_req(0, 32'h0000_0010, 32'hA5A5_0001, 4'hF, 1'b0);
    ack_dly   = 3;
    resp_data = 32'h0000_C0DE;
    exp_gnt.push_back(mk_gnt(3'd0, 32'h0000_0010, 32'hA5A5_0001, 4'hF, 1'b0));
    exp_rsp.push_back(mk_rsp(2'b01, 2'b00, 32'h0000_C0DE));
    pend[0] = 1;
    wait_done("wr_done", 50);
    chk("wr_cs_len", last_cs_len, 3);

    // Timeout on requester 1; requester inputs change mid-transaction
    set_req(1, 32'h0000_0104, 32'h0, 4'h0, 1'b1);
    ack_dly = 0;
    exp_gnt.push_back(mk_gnt(3'd1, 32'h0000_0104, 32'h0, 4'h0, 1'b1));
    exp_rsp.push_back(mk_rsp(2'b00, 2'b10, 32'hFFFF_FFFF));
    pend[1] = 1;
    wait_cs("to_cs_seen", 20);
    repeat (10) @(posedge core_clk);
    #1;
    set_req(1, 32'hDEAD_0000, 32'h1, 4'h3, 1'b0);
    @(negedge core_clk);
    chk("to_addr_frozen", bus.dbi_addr,    32'h0000_0104);
    chk("to_cs2_frozen",  bus.dbi_cs2_exp, 1'b1);
    chk("to_wr_frozen",   bus.dbi_wr,      4'h0);
    wait_done("to_done", 400);
    chk("to_cs_len", last_cs_len, TO);

    // Round-robin: both requesters, two transactions each, immediate ack
    set_req(0, 32'h0000_0020, 32'h1111_0000, 4'h3, 1'b0);
    set_req(1, 32'h0000_0024, 32'h2222_0000, 4'hC, 1'b0);
    ack_dly   = 1;
    resp_data = 32'h5555_AAAA;
    rise_cyc.delete();
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        exp_gnt.push_back(mk_gnt(3'd0, 32'h0000_0020, 32'h1111_0000, 4'h3, 1'b0));
        exp_rsp.push_back(mk_rsp(2'b01, 2'b00, 32'h5555_AAAA));
      end else begin
        exp_gnt.push_back(mk_gnt(3'd1, 32'h0000_0024, 32'h2222_0000, 4'hC, 1'b0));
        exp_rsp.push_back(mk_rsp(2'b10, 2'b00, 32'h5555_AAAA));
      end
    end
    pend[0] = 2;
    pend[1] = 2;
    wait_done("rr_done", 100);
    chk("rr_rises", rise_cyc.size(), 4);
    for (int k = 1; k < rise_cyc.size(); k++) begin
      chk("rr_spacing", rise_cyc[k] - rise_cyc[k-1], 3);
    end

    // Ack arrives on the final timeout cycle: ack wins
    set_req(0, 32'h0000_0030, 32'h0, 4'h0, 1'b0);
    ack_dly   = TO;
    resp_data = 32'h1234_5678;
    exp_gnt.push_back(mk_gnt(3'd0, 32'h0000_0030, 32'h0, 4'h0, 1'b0));
    exp_rsp.push_back(mk_rsp(2'b01, 2'b00, 32'h1234_5678));
    pend[0] = 1;
    wait_done("last_done", 400);
    chk("last_cs_len", last_cs_len, TO);

    // dbi_ready gating
    bus.dbi_ready = 1'b0;
    set_req(0, 32'h0000_0040, 32'h4040_4040, 4'h1, 1'b0);
    ack_dly   = 1;
    resp_data = 32'h0000_0040;
    exp_gnt.push_back(mk_gnt(3'd0, 32'h0000_0040, 32'h4040_4040, 4'h1, 1'b0));
    exp_rsp.push_back(mk_rsp(2'b01, 2'b00, 32'h0000_0040));
    pend[0] = 1;
    n_hi = 0;
    repeat (50) begin
      @(negedge core_clk);
      if (bus.dbi_cs !== 1'b0 || bus.busy !== 1'b0) n_hi++;
    end
    chk("gate_cs_low", n_hi, 0);
    @(posedge core_clk);
    #1;
    bus.dbi_ready = 1'b1;
    @(posedge core_clk);
    @(negedge core_clk);
    chk("gate_cs_rise", bus.dbi_cs, 1'b1);
    wait_done("gate_done", 50);

    // Asynchronous reset while requester 1 holds the bus
    set_req(1, 32'h0000_0050, 32'h0000_0005, 4'hF, 1'b0);
    ack_dly = 0;
    exp_gnt.push_back(mk_gnt(3'd1, 32'h0000_0050, 32'h0000_0005, 4'hF, 1'b0));
    pend[1] = 1;
    wait_cs("rst_cs_seen", 20);
    @(posedge core_clk);
    #3;
    core_rst = 1'b1;
    #1;
    chk("arst_cs",    bus.dbi_cs,   1'b0);
    chk("arst_busy",  bus.busy,     1'b0);
    chk("arst_ack",   bus.req_ack,  2'b00);
    chk("arst_err",   bus.req_err,  2'b00);
    chk("arst_grant", bus.grant_id, 3'd0);
    set_req(0, 32'h0000_0060, 32'h0000_0006, 4'hF, 1'b0);
    ack_dly   = 1;
    resp_data = 32'h0000_6666;
    exp_gnt.push_back(mk_gnt(3'd0, 32'h0000_0060, 32'h0000_0006, 4'hF, 1'b0));
    exp_gnt.push_back(mk_gnt(3'd1, 32'h0000_0050, 32'h0000_0005, 4'hF, 1'b0));
    exp_rsp.push_back(mk_rsp(2'b01, 2'b00, 32'h0000_6666));
    exp_rsp.push_back(mk_rsp(2'b10, 2'b00, 32'h0000_6666));
    pend[0] = 1;
    repeat (3) @(posedge core_clk);
    #1;
    core_rst = 1'b0;
    wait_done("post_rst_done", 50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
